led_pulse_fsm: RTL and testbench

Output-side counterpart to the switch debouncer: converts single-cycle event pulses from the core logic into LED flashes that are long enough to see. Every accepted event produces one flash with a guaranteed minimum on-time, followed by a guaranteed minimum dark gap. Events that arrive during a flash are queued and replayed, so rapid events show as separate blinks. The block sits between the stack control logic and each board LED pin.

---
 rtl/led_pulse_fsm.sv | 169 ++++++++++++++++
 tb/tb_led_pulse_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_fsm.sv
// Stretches single-cycle event pulses into visible LED flashes with a minimum on-time and dark gap.
// Define LED_PULSE_QUEUE_EN to queue events that arrive mid-flash and replay them as separate blinks.
module led_pulse_fsm #(
  parameter int unsigned N         = 19,
  parameter int unsigned ON_TICKS  = 3,
  parameter int unsigned OFF_TICKS = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pend,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [N-1:0] Q_MAX    = '1;
  localparam logic [N-1:0] Q_ONE    = N'(1);
  localparam logic [7:0]   ON_LAST  = 8'(ON_TICKS - 1);
  localparam logic [7:0]   OFF_LAST = 8'(OFF_TICKS - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic [7:0]     t_q, t_d;
  logic           ovf_q, ovf_d;
  logic           led_q, led_d;
  logic           busy_q, busy_d;
  logic           tick_s;
  logic           on_done_s;
  logic           gap_done_s;
  logic           has_pend_s;
  logic           enter_s;
  logic           ev_busy_s;

  assign tick_s     = (q_q == Q_MAX);
  assign on_done_s  = tick_s && (t_q == ON_LAST);
  assign gap_done_s = tick_s && (t_q == OFF_LAST);
  assign enter_s    = (state_d != state_q);
  assign ev_busy_s  = ev && (state_q != S_IDLE);

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ev || has_pend_s) begin
          state_d = S_ON;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (on_done_s) begin
          state_d = S_GAP;
        end else begin
          state_d = S_ON;
        end
      end
      S_GAP: begin
        if (gap_done_s) begin
          state_d = has_pend_s ? S_ON : S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler and tick counter restart on every state entry
  always_comb begin
    if (enter_s) begin
      q_d = '0;
      t_d = 8'd0;
    end else begin
      q_d = q_q + Q_ONE;
      t_d = tick_s ? (t_q + 8'd1) : t_q;
    end
  end

  // Output decode of the next state, registered alongside the state
  always_comb begin
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

`ifdef LED_PULSE_QUEUE_EN
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pend_q, pend_d;
  logic             consume_s;

  assign has_pend_s = (pend_q != '0);
  // A queued event is used when IDLE replays it or a GAP rolls straight into the next flash
  assign consume_s  = ((state_q == S_IDLE) && !ev && has_pend_s) ||
                      ((state_q == S_GAP) && gap_done_s && has_pend_s);

  // Pending-event counter with saturation and overflow capture
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (ev_busy_s) begin
      if (consume_s) begin
        pend_d = pend_q;
      end else if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (consume_s) begin
      pend_d = pend_q - PEND_ONE;
    end else begin
      pend_d = pend_q;
    end
  end

  // Queue register
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign has_pend_s = 1'b0;

  // Without a queue every event that arrives mid-flash is lost
  always_comb begin
    ovf_d = ovf_q | ev_busy_s;
  end

  assign pend = '0;
`endif

  // State, timers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      t_q     <= 8'd0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      t_q     <= t_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_led_pulse_fsm.sv
// Self-checking bench for led_pulse_fsm: vector table, directed flash sequences and random traffic
// checked against a phase/duration model. Honours LED_PULSE_QUEUE_EN like the design.
module tb_led_pulse_fsm;

  localparam int N      = 4;
  localparam int ON_T   = 3;
  localparam int OFF_T  = 2;
  localparam int CW     = 2;
  localparam int ON_LEN  = ON_T * (1 << N);
  localparam int OFF_LEN = OFF_T * (1 << N);
  localparam int PMAX    = (1 << CW) - 1;
`ifdef LED_PULSE_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ev;
  logic          led;
  logic          busy;
  logic [CW-1:0] pend;
  logic          ovf;

  always #5 clk = ~clk;

  led_pulse_fsm #(
    .N(N), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .ev(ev),
    .led(led), .busy(busy), .pend(pend), .ovf(ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference: phase 0 idle, 1 lit, 2 dark gap; rem = cycles left in the phase
  int m_phase = 0;
  int m_rem   = 0;
  int m_pend  = 0;
  bit m_ovf   = 1'b0;

  typedef struct {
    logic       e;
    logic       r;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tv[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic e, input logic r);
    int np;
    int nr;
    bit consume;
    if (r) begin
      m_phase = 0; m_rem = 0; m_pend = 0; m_ovf = 1'b0;
      return;
    end
    consume = 1'b0;
    np = m_phase;
    nr = m_rem - 1;
    if (m_phase == 0) begin
      if (e || m_pend > 0) begin
        np = 1; nr = ON_LEN; consume = !e;
      end
    end else if (m_phase == 1) begin
      if (m_rem == 1) begin
        np = 2; nr = OFF_LEN;
      end
    end else begin
      if (m_rem == 1) begin
        if (QEN && m_pend > 0) begin
          np = 1; nr = ON_LEN; consume = 1'b1;
        end else begin
          np = 0;
        end
      end
    end
    if (e && m_phase != 0) begin
      if (!QEN) m_ovf = 1'b1;
      else if (!consume) begin
        if (m_pend == PMAX) m_ovf = 1'b1;
        else m_pend++;
      end
    end else if (consume) begin
      m_pend--;
    end
    m_phase = np;
    m_rem   = nr;
  endtask

  task automatic do_cycle(input logic e, input logic r);
    ev = e;
    reset = r;
    @(posedge clk);
    model_step(e, r);
    cyc++;
    @(negedge clk);
    check("model_led",  led,  (m_phase == 1));
    check("model_busy", busy, (m_phase != 0));
    check("model_pend", pend, m_pend);
    check("model_ovf",  ovf,  m_ovf);
  endtask

  task automatic start_scn();
    do_cycle(1'b0, 1'b1);
    cyc = 0;
  endtask

  initial begin
    int p;
    ev = 1'b0;
    reset = 1'b1;

    tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
    tv[3] = '{1'b1, 1'b0, 1'b1, 1'b1, (QEN ? 2'd1 : 2'd0), !QEN};
    tv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, (QEN ? 2'd2 : 2'd0), !QEN};
    tv[5] = '{1'b0, 1'b0, 1'b1, 1'b1, (QEN ? 2'd2 : 2'd0), !QEN};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tv[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tv[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      do_cycle(tv[i].e, tv[i].r);
      check("tv_led",  led,  tv[i].led);
      check("tv_busy", busy, tv[i].busy);
      check("tv_pend", pend, tv[i].pend);
      check("tv_ovf",  ovf,  tv[i].ovf);
    end

    // Single flash timing
    start_scn();
    for (int c = 0; c < 100; c++) begin
      do_cycle(c == 10, 1'b0);
      case (cyc)
        10: check("s1_led_before", led, 0);
        11: check("s1_led_first", led, 1);
        58: check("s1_led_last", led, 1);
        59: begin check("s1_led_off", led, 0); check("s1_busy_gap", busy, 1); end
        90: check("s1_busy_last", busy, 1);
        91: begin check("s1_busy_idle", busy, 0); check("s1_pend", pend, 0); end
        default: ;
      endcase
    end

    // Events during a flash
    start_scn();
    for (int c = 0; c < 210; c++) begin
`ifdef LED_PULSE_QUEUE_EN
      do_cycle(c == 10 || c == 20 || c == 30, 1'b0);
      case (cyc)
        21: check("s2_pend1", pend, 1);
        31: check("s2_pend2", pend, 2);
        90: check("s2_led_gap", led, 0);
        91: check("s2_led_second", led, 1);
        170: begin check("s2_led_gap2", led, 0); check("s2_pend_before", pend, 1); end
        171: begin check("s2_led_third", led, 1); check("s2_pend_empty", pend, 0); end
        200: check("s2_ovf", ovf, 0);
        default: ;
      endcase
`else
      do_cycle(c == 10 || c == 20, 1'b0);
      case (cyc)
        20: check("s2_ovf_before", ovf, 0);
        21: begin check("s2_ovf_set", ovf, 1); check("s2_pend", pend, 0); end
        58: check("s2_led_last", led, 1);
        91: begin check("s2_led_none", led, 0); check("s2_busy_idle", busy, 0); end
        default: ;
      endcase
`endif
    end

    // Event held high for six cycles
    start_scn();
    for (int c = 0; c < 120; c++) begin
      do_cycle(c >= 10 && c <= 15, 1'b0);
      case (cyc)
`ifdef LED_PULSE_QUEUE_EN
        14: begin check("s3_pend_sat", pend, 3); check("s3_ovf_clear", ovf, 0); end
        15: check("s3_ovf_set", ovf, 1);
        119: check("s3_ovf_sticky", ovf, 1);
`else
        11: check("s3_ovf_clear", ovf, 0);
        12: begin check("s3_ovf_set", ovf, 1); check("s3_pend", pend, 0); end
        119: check("s3_ovf_sticky", ovf, 1);
`endif
        default: ;
      endcase
    end

    // Reset in the middle of a flash, with an event in the reset cycle
    start_scn();
    for (int c = 0; c < 80; c++) begin
      do_cycle(c == 10 || c == 20 || c == 40, c == 40);
      case (cyc)
        40: check("s4_led_lit", led, 1);
        41: begin
          check("s4_led", led, 0); check("s4_busy", busy, 0);
          check("s4_pend", pend, 0); check("s4_ovf", ovf, 0);
        end
        60: begin check("s4_no_flash_led", led, 0); check("s4_no_flash_busy", busy, 0); end
        default: ;
      endcase
    end

    // Event in the final GAP cycle
    start_scn();
    for (int c = 0; c < 150; c++) begin
      do_cycle(c == 10 || c == 90, 1'b0);
      case (cyc)
`ifdef LED_PULSE_QUEUE_EN
        91: begin check("s6_idle_busy", busy, 0); check("s6_idle_led", led, 0); check("s6_pend", pend, 1); end
        92: begin check("s6_led_on", led, 1); check("s6_pend_used", pend, 0); end
        139: check("s6_led_last", led, 1);
        140: check("s6_led_off", led, 0);
`else
        91: begin check("s6_ovf", ovf, 1); check("s6_busy", busy, 0); end
        92: check("s6_led_none", led, 0);
`endif
        default: ;
      endcase
    end

    // Random traffic with occasional resets
    start_scn();
    p = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) p = $urandom_range(1, 60);
      do_cycle($urandom_range(0, 99) < p, $urandom_range(0, 399) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
